// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard that stalls the ID stage until each source operand is
// forwardable to EX (non-branch consumers) or to the ID branch comparator (branches).
module hazard_scoreboard #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned ALU_LAT  = 1,
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              id_valid_i,
  input  logic              id_is_branch_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic              id_rs_used_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_rt_used_i,
  input  logic [REG_AW-1:0] id_dst_i,
  input  logic              id_wen_i,
  input  logic              id_mem_read_i,
  input  logic              id_flush_i,
  input  logic              ex_hold_i,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic              id_ex_write_o,
  output logic              id_ex_bubble_o,
  output logic [1:0]        stall_cause_o,
  output logic [CNT_W-1:0]  stall_count_o
);

  localparam int unsigned NumRegs = 2 ** REG_AW;
  localparam int unsigned LatW    = $clog2(LOAD_LAT + 1);

  localparam logic [1:0] CauseNone   = 2'd0;
  localparam logic [1:0] CauseExHaz  = 2'd1;
  localparam logic [1:0] CauseBrHaz  = 2'd2;
  localparam logic [1:0] CauseHold   = 2'd3;

  logic [LatW-1:0]  cnt_q [NumRegs];
  logic [LatW-1:0]  cnt_d [NumRegs];
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [LatW-1:0] rs_cnt, rt_cnt;
  logic            rs_live, rt_live;
  logic            haz_ex, haz_br, issue;

  always_comb begin
    rs_cnt  = cnt_q[id_rs_i];
    rt_cnt  = cnt_q[id_rt_i];
    rs_live = id_rs_used_i && (id_rs_i != '0);
    rt_live = id_rt_used_i && (id_rt_i != '0);
    // A count of 1 means the value is already in the EX forwarding path but not yet at ID.
    haz_ex  = id_valid_i && !id_is_branch_i &&
              ((rs_live && (rs_cnt > LatW'(1))) || (rt_live && (rt_cnt > LatW'(1))));
    haz_br  = id_valid_i && id_is_branch_i &&
              ((rs_live && (rs_cnt != '0)) || (rt_live && (rt_cnt != '0)));
  end

  always_comb begin
    pc_write_o     = 1'b1;
    if_id_write_o  = 1'b1;
    id_ex_write_o  = 1'b1;
    id_ex_bubble_o = 1'b0;
    stall_cause_o  = CauseNone;
    if (ex_hold_i) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      id_ex_write_o = 1'b0;
      stall_cause_o = CauseHold;
    end else if (id_flush_i) begin
      id_ex_bubble_o = 1'b1;
    end else if (haz_br || haz_ex) begin
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      id_ex_bubble_o = 1'b1;
      stall_cause_o  = haz_br ? CauseBrHaz : CauseExHaz;
    end
  end

  assign issue = id_valid_i && id_wen_i && (id_dst_i != '0) &&
                 (stall_cause_o == CauseNone) && !id_flush_i;

  always_comb begin
    for (int unsigned r = 0; r < NumRegs; r++) begin
      cnt_d[r] = cnt_q[r];
      if (!ex_hold_i && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - LatW'(1);
      end
    end
    // Newest writer overrides any older in-flight count for the same register.
    if (issue) begin
      cnt_d[id_dst_i] = id_mem_read_i ? LatW'(LOAD_LAT) : LatW'(ALU_LAT);
    end
    cnt_d[0] = '0;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((stall_cause_o != CauseNone) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned r = 0; r < NumRegs; r++) begin
        cnt_q[r] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int unsigned r = 0; r < NumRegs; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count_o = stall_cnt_q;

endmodule
